lab3_cache_line_xfer_unit: RTL and testbench

- Sits directly downstream of the blocking cache, between the cache's refill/evict port and the 4B-word memory port.
- Accepts one 64B (512-bit) line request: a read is a refill and a write is an eviction.
- Breaks the line into 16 sequential 4B memory transactions and pipelines up to p_max_inflight of them.
- For a refill, reassembles the response words into a 512-bit line returned to the cache. For an eviction, returns a write acknowledgement.

---
 rtl/lab3_cache_line_xfer_unit.sv | 175 +++++++++++++++++
 tb/tb_lab3_cache_line_xfer_unit.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab3_cache_line_xfer_unit.sv
// Cache line transfer unit: splits one 64B line request into sixteen 4B
// memory transactions, keeps a bounded number of them in flight, and
// returns either the reassembled line (refill) or a write acknowledgement
// (evict) to the cache.
module lab3_cache_line_xfer_unit #(
  parameter int unsigned p_max_inflight = 4,
  parameter int unsigned p_nwords       = 16
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         linereq_val,
  output logic         linereq_rdy,
  input  logic         linereq_type,
  input  logic [31:0]  linereq_addr,
  input  logic [511:0] linereq_data,

  output logic         lineresp_val,
  input  logic         lineresp_rdy,
  output logic         lineresp_type,
  output logic [511:0] lineresp_data,

  output logic         memreq_val,
  input  logic         memreq_rdy,
  output logic         memreq_type,
  output logic [31:0]  memreq_addr,
  output logic [31:0]  memreq_data,

  input  logic         memresp_val,
  output logic         memresp_rdy,
  input  logic [31:0]  memresp_data
);

  // Counters span 0..p_nwords inclusive, so they need one bit more than a
  // word index.
  localparam logic [4:0] cnt_last   = 5'(p_nwords);
  localparam logic [4:0] cnt_max_if = 5'(p_max_inflight);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic [31:0]  base_reg;
  logic         type_reg;
  logic [4:0]   req_cnt_reg, req_cnt_next;
  logic [4:0]   resp_cnt_reg, resp_cnt_next;
  logic [511:0] line_flat;

  logic [4:0]   inflight;
  logic         accept;
  logic         issue;
  logic         resp_fire;
  logic         in_xfer;
  logic         addr_unused;

  // The low six address bits select a byte inside the line and are dropped.
  assign addr_unused = ^linereq_addr[5:0];

  assign in_xfer  = (state_reg == XFER);
  assign inflight = req_cnt_reg - resp_cnt_reg;

  // Handshake qualifiers. A response with nothing outstanding is a protocol
  // error on the memory side and is dropped without counting.
  assign accept    = linereq_val && linereq_rdy;
  assign issue     = memreq_val && memreq_rdy;
  assign resp_fire = in_xfer && memresp_val && (inflight != 5'd0);

  // State and counter registers; reset abandons any transfer in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      req_cnt_reg  <= 5'd0;
      resp_cnt_reg <= 5'd0;
    end else begin
      state_reg    <= state_next;
      req_cnt_reg  <= req_cnt_next;
      resp_cnt_reg <= resp_cnt_next;
    end
  end

  // Captured request attributes, held for the whole transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_reg <= 32'd0;
      type_reg <= 1'b0;
    end else if (accept) begin
      base_reg <= {linereq_addr[31:6], 6'b0};
      type_reg <= linereq_type;
    end
  end

  // Next-state and counter update. Issue and response can land in the same
  // cycle; both counters then move and the in-flight count is unchanged.
  always_comb begin
    state_next    = state_reg;
    req_cnt_next  = req_cnt_reg;
    resp_cnt_next = resp_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next    = XFER;
          req_cnt_next  = 5'd0;
          resp_cnt_next = 5'd0;
        end
      end
      XFER: begin
        if (issue) begin
          req_cnt_next = req_cnt_reg + 5'd1;
        end
        if (resp_fire) begin
          resp_cnt_next = resp_cnt_reg + 5'd1;
        end
        // The response cycle follows the one in which the last word landed.
        if (resp_cnt_next == cnt_last) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (lineresp_rdy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Line buffer, one 32-bit register per word. An evict loads the outgoing
  // data; a refill starts from zero and is filled word by word in response
  // order, so nothing from an earlier line can leak into the result.
  for (genvar gi = 0; gi < 16; gi++) begin : g_word
    logic [31:0] word_reg;

    // Per-word load on capture or on the matching refill response.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        word_reg <= 32'd0;
      end else if (accept) begin
        word_reg <= linereq_type ? linereq_data[32*gi +: 32] : 32'd0;
      end else if (resp_fire && !type_reg && (resp_cnt_reg == 5'(gi))) begin
        word_reg <= memresp_data;
      end
    end

    assign line_flat[32*gi +: 32] = word_reg;
  end

  // Output decode. Everything is qualified by state (and reset for the
  // request-ready), so an asserted reset drives every output low at once.
  always_comb begin
    linereq_rdy   = (state_reg == IDLE) && reset;

    memreq_val    = in_xfer && (req_cnt_reg < cnt_last) && (inflight < cnt_max_if);
    memreq_type   = in_xfer && type_reg;
    memreq_addr   = 32'd0;
    memreq_data   = 32'd0;
    if (in_xfer) begin
      memreq_addr = base_reg + {25'd0, req_cnt_reg, 2'b00};
      if (type_reg && (req_cnt_reg < cnt_last)) begin
        memreq_data = line_flat[{req_cnt_reg[3:0], 5'b0} +: 32];
      end
    end

    memresp_rdy   = in_xfer;

    lineresp_val  = (state_reg == RESP);
    lineresp_type = (state_reg == RESP) && type_reg;
    lineresp_data = ((state_reg == RESP) && !type_reg) ? line_flat : 512'd0;
  end

endmodule

// File: tb/tb_lab3_cache_line_xfer_unit.sv
// Bench for the cache line transfer unit: two instances (in-flight limit 4
// and 1), a behavioural word memory per instance, directed cases from the
// test plan followed by randomized line traffic.
`timescale 1ns/1ps
module tb_lab3_cache_line_xfer_unit;
  localparam int NI = 2;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } pend_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         lreq_val   [NI];
  logic         lreq_rdy   [NI];
  logic         lreq_type  [NI];
  logic [31:0]  lreq_addr  [NI];
  logic [511:0] lreq_data  [NI];
  logic         lresp_val  [NI];
  logic         lresp_rdy  [NI];
  logic         lresp_type [NI];
  logic [511:0] lresp_data [NI];
  logic         mreq_val   [NI];
  logic         mreq_rdy   [NI];
  logic         mreq_type  [NI];
  logic [31:0]  mreq_addr  [NI];
  logic [31:0]  mreq_data  [NI];
  logic         mresp_val  [NI];
  logic         mresp_rdy  [NI];
  logic [31:0]  mresp_data [NI];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Test configuration and model state shared between stimulus and monitors.
  int           lat_cfg  [NI];
  int           rdy_mode [NI];
  int           hold_cfg [NI];
  logic         active   [NI];
  logic         done     [NI];
  logic         exp_type [NI];
  logic [31:0]  exp_base [NI];
  logic [511:0] exp_data [NI];
  int           exp_start[NI];
  int           acc_cyc  [NI];
  int           rise_cyc [NI];
  int           hs_cyc   [NI];
  int           n_issued [NI];
  int           n_resp   [NI];
  int           max_seen [NI];
  logic [511:0] got_line [NI];
  logic         got_type [NI];
  logic [31:0]  wlog_addr[NI][16];
  logic [31:0]  wlog_data[NI][16];

  initial forever @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Contents of never-written memory: low nibble is the word index inside
  // the line, and the line number is folded in so that different lines
  // differ (line 0x1200 reads as 0xA000_0000 + i).
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return 32'hA000_0000 + ((a >> 2) & 32'hF) + (((a >> 6) ^ 32'h48) << 8);
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int P = (gi == 0) ? 4 : 1;

    lab3_cache_line_xfer_unit #(.p_max_inflight(P), .p_nwords(16)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .linereq_val  (lreq_val[gi]),
      .linereq_rdy  (lreq_rdy[gi]),
      .linereq_type (lreq_type[gi]),
      .linereq_addr (lreq_addr[gi]),
      .linereq_data (lreq_data[gi]),
      .lineresp_val (lresp_val[gi]),
      .lineresp_rdy (lresp_rdy[gi]),
      .lineresp_type(lresp_type[gi]),
      .lineresp_data(lresp_data[gi]),
      .memreq_val   (mreq_val[gi]),
      .memreq_rdy   (mreq_rdy[gi]),
      .memreq_type  (mreq_type[gi]),
      .memreq_addr  (mreq_addr[gi]),
      .memreq_data  (mreq_data[gi]),
      .memresp_val  (mresp_val[gi]),
      .memresp_rdy  (mresp_rdy[gi]),
      .memresp_data (mresp_data[gi])
    );

    pend_t       pq[$];
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return dflt(a);
    endfunction

    // Memory model plus per-cycle comparison of every DUT output against
    // what the line-level model says must happen this cycle.
    initial begin : p_mem
      int           inflight0;
      int           nresp0;
      int           idx;
      int           hold_cnt;
      logic         r;
      logic         rr;
      logic         prev_wait;
      logic         prev_type;
      logic [511:0] prev_data;
      logic [511:0] expl;
      hold_cnt  = 0;
      prev_wait = 1'b0;
      prev_type = 1'b0;
      prev_data = '0;
      mreq_rdy[gi]   = 1'b0;
      mresp_val[gi]  = 1'b0;
      mresp_data[gi] = 32'd0;
      lresp_rdy[gi]  = 1'b0;
      forever begin
        @(negedge clk);
        #1;
        if (!reset) begin
          pq.delete();
          n_issued[gi]   = 0;
          n_resp[gi]     = 0;
          mreq_rdy[gi]   = 1'b0;
          mresp_val[gi]  = 1'b0;
          lresp_rdy[gi]  = 1'b0;
          hold_cnt       = 0;
          prev_wait      = 1'b0;
        end else begin
          inflight0 = n_issued[gi] - n_resp[gi];
          nresp0    = n_resp[gi];

          if (pq.size() > 0 && pq[0].ready <= cyc) begin
            mresp_val[gi]  = 1'b1;
            mresp_data[gi] = rd(pq[0].addr);
          end else begin
            mresp_val[gi]  = 1'b0;
            mresp_data[gi] = $urandom;
          end

          case (rdy_mode[gi])
            0:       r = 1'b1;
            1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: r = 1'($urandom_range(0, 1));
          endcase
          mreq_rdy[gi] = r;

          chk("memreq_val", 512'(mreq_val[gi]),
              512'(active[gi] && cyc >= exp_start[gi] && n_issued[gi] < 16 && inflight0 < P));
          chk("memresp_rdy", 512'(mresp_rdy[gi]),
              512'(active[gi] && cyc >= exp_start[gi] && nresp0 < 16));

          if (mreq_val[gi] && r) begin
            idx = n_issued[gi];
            if (idx < 16) begin
              chk("memreq_addr", 512'(mreq_addr[gi]), 512'(exp_base[gi] + 32'(4 * idx)));
              chk("memreq_type", 512'(mreq_type[gi]), 512'(exp_type[gi]));
              chk("memreq_data", 512'(mreq_data[gi]),
                  512'(exp_type[gi] ? exp_data[gi][32*idx +: 32] : 32'h0));
              wlog_addr[gi][idx] = mreq_addr[gi];
              wlog_data[gi][idx] = mreq_data[gi];
            end
            if (mreq_type[gi]) mem[mreq_addr[gi]] = mreq_data[gi];
            pq.push_back('{addr: mreq_addr[gi], ready: cyc + lat_cfg[gi]});
            n_issued[gi]++;
            if (inflight0 + 1 > max_seen[gi]) max_seen[gi] = inflight0 + 1;
          end

          if (mresp_val[gi] && mresp_rdy[gi]) begin
            pq.delete(0);
            n_resp[gi]++;
          end

          chk("lineresp_val", 512'(lresp_val[gi]), 512'(active[gi] && nresp0 == 16));
          if (lresp_val[gi]) begin
            if (hold_cnt == 0) rise_cyc[gi] = cyc;
            chk("linereq_rdy_in_resp", 512'(lreq_rdy[gi]), 512'(1'b0));
            if (prev_wait) begin
              chk("lineresp_data_stable", lresp_data[gi], prev_data);
              chk("lineresp_type_stable", 512'(lresp_type[gi]), 512'(prev_type));
            end
            rr = (hold_cnt >= hold_cfg[gi]);
            lresp_rdy[gi] = rr;
            hold_cnt++;
            if (rr) begin
              for (int i = 0; i < 16; i++)
                expl[32*i +: 32] = exp_type[gi] ? 32'h0 : rd(exp_base[gi] + 32'(4 * i));
              chk("lineresp_type", 512'(lresp_type[gi]), 512'(exp_type[gi]));
              chk("lineresp_data", lresp_data[gi], expl);
              got_line[gi] = lresp_data[gi];
              got_type[gi] = lresp_type[gi];
              hs_cyc[gi]   = cyc;
              done[gi]     = 1'b1;
              active[gi]   = 1'b0;
              n_issued[gi] = 0;
              n_resp[gi]   = 0;
              hold_cnt     = 0;
              prev_wait    = 1'b0;
            end else begin
              prev_wait = 1'b1;
              prev_data = lresp_data[gi];
              prev_type = lresp_type[gi];
            end
          end else begin
            lresp_rdy[gi] = 1'($urandom_range(0, 1));
            hold_cnt      = 0;
            prev_wait     = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk_idle(input int k, input string name, input logic exp_rdy);
    chk({name, "_lreq_rdy"}, 512'(lreq_rdy[k]), 512'(exp_rdy));
    chk({name, "_outputs"},
        512'({lresp_val[k], lresp_type[k], mreq_val[k], mreq_type[k],
              mreq_addr[k], mreq_data[k], mresp_rdy[k]}) | lresp_data[k], 512'd0);
  endtask

  task automatic send_line(input int k, input logic t, input logic [31:0] a, input logic [511:0] d);
    int b;
    b = 200;
    @(negedge clk);
    lreq_val[k]  = 1'b1;
    lreq_type[k] = t;
    lreq_addr[k] = a;
    lreq_data[k] = d;
    while (!lreq_rdy[k] && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk("linereq_accept_timeout", 512'(lreq_rdy[k]), 512'(1'b1));
    done[k]      = 1'b0;
    max_seen[k]  = 0;
    exp_type[k]  = t;
    exp_base[k]  = {a[31:6], 6'b0};
    exp_data[k]  = d;
    exp_start[k] = cyc + 1;
    acc_cyc[k]   = cyc;
    active[k]    = 1'b1;
    @(negedge clk);
    lreq_val[k]  = 1'b0;
    lreq_addr[k] = $urandom;
    lreq_type[k] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int k);
    int b;
    b = 2000;
    while (!done[k] && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk("line_done_timeout", 512'(done[k]), 512'(1'b1));
  endtask

  task automatic cfg(input int k, input int lat, input int mode, input int hold);
    lat_cfg[k]  = lat;
    rdy_mode[k] = mode;
    hold_cfg[k] = hold;
  endtask

  initial begin : p_main
    logic [511:0] d;
    int           b;
    int           k;
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      lreq_val[i] = 1'b0; lreq_type[i] = 1'b0; lreq_addr[i] = 32'd0; lreq_data[i] = '0;
      active[i] = 1'b0; done[i] = 1'b0; exp_start[i] = 0; exp_type[i] = 1'b0;
      exp_base[i] = 32'd0; exp_data[i] = '0; n_issued[i] = 0; n_resp[i] = 0;
      max_seen[i] = 0; rise_cyc[i] = 0; hs_cyc[i] = 0; acc_cyc[i] = 0;
      cfg(i, 1, 0, 0);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) chk_idle(i, "in_reset", 1'b0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk_idle(i, "after_reset", 1'b1);

    // Zero-wait refill at 0x1234.
    cfg(0, 1, 0, 0);
    send_line(0, 1'b0, 32'h0000_1234, '0);
    wait_done(0);
    chk("t1_word0", 512'(got_line[0][31:0]), 512'(32'hA000_0000));
    chk("t1_word15", 512'(got_line[0][511:480]), 512'(32'hA000_000F));
    chk("t1_addr0", 512'(wlog_addr[0][0]), 512'(32'h0000_1200));
    chk("t1_addr15", 512'(wlog_addr[0][15]), 512'(32'h0000_123C));
    chk("t1_type", 512'(got_type[0]), 512'(1'b0));
    chk("t1_latency", 512'(rise_cyc[0] - acc_cyc[0]), 512'(18));

    // Evict at 0x840, word i = i * 0x11111111.
    for (int i = 0; i < 16; i++) d[32*i +: 32] = 32'(i) * 32'h1111_1111;
    send_line(0, 1'b1, 32'h0000_0840, d);
    wait_done(0);
    chk("t2_addr3", 512'(wlog_addr[0][3]), 512'(32'h0000_084C));
    chk("t2_data3", 512'(wlog_data[0][3]), 512'(32'h3333_3333));
    chk("t2_data15", 512'(wlog_data[0][15]), 512'(32'hFFFF_FFFF));
    chk("t2_resp_data", got_line[0], 512'd0);
    chk("t2_type", 512'(got_type[0]), 512'(1'b1));

    // Backpressure: request ready 1,0,0,1 and three-cycle response delay.
    cfg(0, 3, 1, 0);
    send_line(0, 1'b0, 32'h0000_1240, '0);
    wait_done(0);
    chk("t3_word2", 512'(got_line[0][95:64]), 512'(32'hA000_0102));
    chk("t3_inflight_le4", 512'(max_seen[0] <= 4), 512'(1'b1));

    // Line response held off for five cycles.
    cfg(0, 1, 0, 5);
    send_line(0, 1'b0, 32'h0000_0840, '0);
    wait_done(0);
    chk("t4_hold_cycles", 512'(hs_cyc[0] - rise_cyc[0]), 512'(5));
    chk("t4_readback_word5", 512'(got_line[0][191:160]), 512'(32'h5555_5555));

    // Reset in the middle of a refill, then a clean refill at 0x40.
    cfg(0, 2, 0, 0);
    send_line(0, 1'b0, 32'h0000_3000, '0);
    b = 500;
    while (n_issued[0] < 7 && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk("t5_seven_issued", 512'(n_issued[0] >= 7), 512'(1'b1));
    reset     = 1'b0;
    active[0] = 1'b0;
    #1;
    chk_idle(0, "t5_async_reset", 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_idle(0, "t5_after_release", 1'b1);
    cfg(0, 1, 0, 0);
    send_line(0, 1'b0, 32'h0000_0040, '0);
    wait_done(0);
    chk("t5_word0", 512'(got_line[0][31:0]), 512'(32'hA000_4900));
    chk("t5_word15", 512'(got_line[0][511:480]), 512'(32'hA000_490F));

    // Single-outstanding instance with two-cycle memory latency.
    cfg(1, 2, 0, 0);
    send_line(1, 1'b0, 32'h0000_1200, '0);
    wait_done(1);
    chk("t6_max_inflight", 512'(max_seen[1]), 512'(1));
    chk("t6_latency", 512'(rise_cyc[1] - acc_cyc[1]), 512'(49));
    chk("t6_word9", 512'(got_line[1][319:288]), 512'(32'hA000_0009));

    // Randomized traffic over a small set of lines so evicts are read back.
    for (int n = 0; n < 24; n++) begin
      k = $urandom_range(0, NI - 1);
      cfg(k, $urandom_range(1, 4), $urandom_range(0, 2), $urandom_range(0, 3));
      for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
      send_line(k, 1'($urandom_range(0, 1)),
                32'h0000_2000 + 32'($urandom_range(0, 3) * 64) + 32'($urandom_range(0, 63)), d);
      wait_done(k);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : p_watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish by %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
